// File: rtl/neurosync_pkg.sv
// Purpose: shared state encodings and opcode constants for the NeuroSync controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: state_t (4-bit state codes, also exported on db_estado), OP_FAIXA.
package neurosync_pkg;

    typedef enum logic [3:0] {
        ST_INICIAL          = 4'b0000,
        ST_PREPARACAO       = 4'b0001,
        ST_ESCOLHE_MODO     = 4'b0010,
        ST_PREPARA_JOGO     = 4'b0011,
        ST_PREPARA_PERGUNTA = 4'b0100,
        ST_AGUARDA_MED      = 4'b0101,
        ST_AGUARDA_RESP     = 4'b0110,
        ST_ESTOURO          = 4'b0111,
        ST_FEEDBACK         = 4'b1000,
        ST_GANHOU           = 4'b1001,
        ST_PROXIMA_PERGUNTA = 4'b1010,
        ST_PERDEU           = 4'b1011
    } state_t;

    // Opcode that selects a band measurement instead of a play.
    localparam logic [1:0] OP_FAIXA = 2'b11;

endpackage

// File: rtl/neurosync_timeout_timer.sv
// Purpose: per-question response timer; flags expiry on its last allowed count.
// Latency: expired is combinational from the count; count advances one per enabled cycle.
// Backpressure: none; clear has priority over enable, count holds at its last value.
//
// Ports: clock, reset (async, active-high), clear, enable -> expired.
module neurosync_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    localparam int T_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [T_W-1:0] LAST = T_W'(TIMEOUT_CYCLES - 1);

    logic [T_W-1:0] count_q;

    // Counting 0..TIMEOUT_CYCLES-1 and flagging the last value makes the
    // owner leave its wait state exactly TIMEOUT_CYCLES cycles after entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != LAST)) begin
            count_q <= count_q + T_W'(1);
        end
    end

    assign expired = (count_q == LAST);

endmodule

// File: rtl/neurosync_controller_param_uc.sv
// Purpose: NeuroSync game control unit - mode select, per-question sequencing, win/lose.
// Latency: Moore outputs, valid one clock after the input pulse that caused the transition.
// Backpressure: none; pulses arriving in states that do not use them are dropped.
//
// Ports: clock, reset (async, active-high); jogar_det, confirma_det, opcode[1:0],
//   acertou_faixa, acertou_play, pronto_play in; zera, registra_modo, zera_prep_jogo,
//   set_pos, medir, jogando, pergunta[Q_W], erros[E_W], estourou, ganhou_o, perdeu_o,
//   db_estado[3:0] out.
// Build option: define NEUROSYNC_TIMEOUT_EN to enable the response timeout, error
//   counter and lose condition; otherwise the wait states wait forever.
module neurosync_controller_param_uc
    import neurosync_pkg::*;
#(
    parameter int NUM_QUESTIONS  = 8,
    parameter int MAX_ERRORS     = 3,
    parameter int TIMEOUT_CYCLES = 50_000_000,
    localparam int Q_W = $clog2(NUM_QUESTIONS),
    localparam int E_W = $clog2(MAX_ERRORS + 1)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           jogar_det,
    input  logic           confirma_det,
    input  logic [1:0]     opcode,
    input  logic           acertou_faixa,
    input  logic           acertou_play,
    input  logic           pronto_play,
    output logic           zera,
    output logic           registra_modo,
    output logic           zera_prep_jogo,
    output logic           set_pos,
    output logic           medir,
    output logic           jogando,
    output logic [Q_W-1:0] pergunta,
    output logic [E_W-1:0] erros,
    output logic           estourou,
    output logic           ganhou_o,
    output logic           perdeu_o,
    output logic [3:0]     db_estado
);

    // Reject configurations the counters cannot represent.
    if (NUM_QUESTIONS < 2 || MAX_ERRORS < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("neurosync_controller_param_uc: illegal parameter set");
    end

    localparam logic [Q_W-1:0] Q_LAST = Q_W'(NUM_QUESTIONS - 1);

    state_t         state_q;
    state_t         state_d;
    logic [Q_W-1:0] pergunta_q;
    logic           tmo_hit;
    logic           in_wait;

    assign in_wait = (state_q == ST_AGUARDA_MED) || (state_q == ST_AGUARDA_RESP);

`ifdef NEUROSYNC_TIMEOUT_EN
    localparam logic [E_W-1:0] E_MAX  = E_W'(MAX_ERRORS);
    localparam logic [E_W-1:0] E_LAST = E_W'(MAX_ERRORS - 1);

    logic [E_W-1:0] erros_q;
    logic           timer_clear;

    assign timer_clear = (state_q == ST_PREPARACAO) || (state_q == ST_PREPARA_PERGUNTA);

    neurosync_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (in_wait),
        .expired (tmo_hit)
    );

    // Cleared on the way into preparacao so a new game shows zero at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            erros_q <= '0;
        end else if (state_d == ST_PREPARACAO) begin
            erros_q <= '0;
        end else if ((state_q == ST_ESTOURO) && (erros_q != E_MAX)) begin
            erros_q <= erros_q + E_W'(1);
        end
    end

    assign erros = erros_q;
`else
    assign tmo_hit = 1'b0;
    assign erros   = '0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_INICIAL;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pergunta_q <= '0;
        end else if (state_d == ST_PREPARACAO) begin
            pergunta_q <= '0;
        end else if ((state_q == ST_PROXIMA_PERGUNTA) && (pergunta_q != Q_LAST)) begin
            pergunta_q <= pergunta_q + Q_W'(1);
        end
    end

    assign pergunta = pergunta_q;

    // Next state. In the wait states a success is checked before expiry so
    // a response landing on the last allowed cycle still counts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INICIAL:          if (jogar_det) state_d = ST_PREPARACAO;
            ST_PREPARACAO:       state_d = ST_ESCOLHE_MODO;
            ST_ESCOLHE_MODO:     if (confirma_det) state_d = ST_PREPARA_JOGO;
            ST_PREPARA_JOGO:     state_d = ST_PREPARA_PERGUNTA;
            ST_PREPARA_PERGUNTA: state_d = (opcode == OP_FAIXA) ? ST_AGUARDA_MED
                                                                : ST_AGUARDA_RESP;
            ST_AGUARDA_MED: begin
                if (acertou_faixa)  state_d = ST_FEEDBACK;
                else if (tmo_hit)   state_d = ST_ESTOURO;
            end
            ST_AGUARDA_RESP: begin
                if (acertou_play && pronto_play) state_d = ST_FEEDBACK;
                else if (tmo_hit)                state_d = ST_ESTOURO;
            end
`ifdef NEUROSYNC_TIMEOUT_EN
            ST_ESTOURO:          state_d = (erros_q == E_LAST) ? ST_PERDEU : ST_FEEDBACK;
            ST_PERDEU:           if (jogar_det) state_d = ST_PREPARACAO;
`endif
            ST_FEEDBACK: begin
                if (confirma_det)
                    state_d = (pergunta_q == Q_LAST) ? ST_GANHOU : ST_PROXIMA_PERGUNTA;
            end
            ST_PROXIMA_PERGUNTA: state_d = ST_PREPARA_PERGUNTA;
            ST_GANHOU:           if (jogar_det) state_d = ST_PREPARACAO;
            default:             state_d = ST_INICIAL;
        endcase
    end

    // Moore output decode.
    always_comb begin
        zera           = 1'b0;
        registra_modo  = 1'b0;
        zera_prep_jogo = 1'b0;
        set_pos        = 1'b0;
        medir          = 1'b0;
        jogando        = 1'b0;
        ganhou_o       = 1'b0;
        case (state_q)
            ST_PREPARACAO:       zera           = 1'b1;
            ST_ESCOLHE_MODO:     registra_modo  = 1'b1;
            ST_PREPARA_JOGO:     zera_prep_jogo = 1'b1;
            ST_PREPARA_PERGUNTA: begin
                set_pos = 1'b1;
                jogando = 1'b1;
            end
            ST_AGUARDA_MED: begin
                medir   = 1'b1;
                jogando = 1'b1;
            end
            ST_AGUARDA_RESP:     jogando        = 1'b1;
            ST_PROXIMA_PERGUNTA: jogando        = 1'b1;
            ST_GANHOU:           ganhou_o       = 1'b1;
            default: ;
        endcase
    end

`ifdef NEUROSYNC_TIMEOUT_EN
    assign estourou = (state_q == ST_ESTOURO);
    assign perdeu_o = (state_q == ST_PERDEU);
`else
    assign estourou = 1'b0;
    assign perdeu_o = 1'b0;
`endif

    assign db_estado = state_q;

endmodule

// File: tb/tb_neurosync_controller_param_uc.sv
// Purpose: self-checking bench for neurosync_controller_param_uc (NQ=2, MAXE=2, TCY=10).
// Latency: n/a.
// Backpressure: n/a.
module tb_neurosync_controller_param_uc;

    localparam int NQ   = 2;
    localparam int MAXE = 2;
    localparam int TCY  = 10;
`ifdef NEUROSYNC_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       jogar_det = 1'b0, confirma_det = 1'b0;
    logic [1:0] opcode = 2'b00;
    logic       acertou_faixa = 1'b0, acertou_play = 1'b0, pronto_play = 1'b0;
    logic       zera, registra_modo, zera_prep_jogo, set_pos, medir, jogando;
    logic [0:0] pergunta;
    logic [1:0] erros;
    logic       estourou, ganhou_o, perdeu_o;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;
    int est_count = 0;

    neurosync_controller_param_uc #(
        .NUM_QUESTIONS  (NQ),
        .MAX_ERRORS     (MAXE),
        .TIMEOUT_CYCLES (TCY)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .jogar_det      (jogar_det),
        .confirma_det   (confirma_det),
        .opcode         (opcode),
        .acertou_faixa  (acertou_faixa),
        .acertou_play   (acertou_play),
        .pronto_play    (pronto_play),
        .zera           (zera),
        .registra_modo  (registra_modo),
        .zera_prep_jogo (zera_prep_jogo),
        .set_pos        (set_pos),
        .medir          (medir),
        .jogando        (jogando),
        .pergunta       (pergunta),
        .erros          (erros),
        .estourou       (estourou),
        .ganhou_o       (ganhou_o),
        .perdeu_o       (perdeu_o),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Game model: phase numbers follow the documented state codes; the
    // question counter and wait time are plain integers.
    int m_st = 0, m_q = 0, m_e = 0, m_w = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_st <= 0; m_q <= 0; m_e <= 0; m_w <= 0;
        end else begin
            case (m_st)
                0: if (jogar_det) begin m_st <= 1; m_q <= 0; m_e <= 0; end
                1: m_st <= 2;
                2: if (confirma_det) m_st <= 3;
                3: m_st <= 4;
                4: begin m_w <= 0; m_st <= (opcode == 2'b11) ? 5 : 6; end
                5, 6: begin
                    if ((m_st == 5) ? acertou_faixa : (acertou_play && pronto_play))
                        m_st <= 8;
                    else if (TMO && m_w == TCY - 1)
                        m_st <= 7;
                    else
                        m_w <= m_w + 1;
                end
                7: begin m_e <= m_e + 1; m_st <= (m_e + 1 == MAXE) ? 11 : 8; end
                8: if (confirma_det) m_st <= (m_q == NQ - 1) ? 9 : 10;
                10: begin m_q <= m_q + 1; m_st <= 4; end
                9, 11: if (jogar_det) begin m_st <= 1; m_q <= 0; m_e <= 0; end
                default: m_st <= 0;
            endcase
        end
    end

    // {zera, registra_modo, zera_prep_jogo, set_pos, medir, jogando, estourou, ganhou_o, perdeu_o}
    function automatic logic [8:0] exp_ctrl(input int st);
        case (st)
            1:       return 9'b1_0000_0000;
            2:       return 9'b0_1000_0000;
            3:       return 9'b0_0100_0000;
            4:       return 9'b0_0010_1000;
            5:       return 9'b0_0001_1000;
            6:       return 9'b0_0000_1000;
            7:       return 9'b0_0000_0100;
            9:       return 9'b0_0000_0010;
            10:      return 9'b0_0000_1000;
            11:      return 9'b0_0000_0001;
            default: return 9'b0_0000_0000;
        endcase
    endfunction

    logic [8:0] ctrl_vec;
    assign ctrl_vec = {zera, registra_modo, zera_prep_jogo, set_pos, medir, jogando,
                       estourou, ganhou_o, perdeu_o};

    always @(negedge clock) begin
        chk("model_state", int'(db_estado), m_st);
        chk("model_ctrl", int'(ctrl_vec), int'(exp_ctrl(m_st)));
        chk("model_pergunta", int'(pergunta), m_q);
        chk("model_erros", int'(erros), m_e);
        if (estourou) est_count++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_jogar();
        jogar_det = 1'b1; tick(1); jogar_det = 1'b0;
    endtask

    task automatic pulse_confirma();
        confirma_det = 1'b1; tick(1); confirma_det = 1'b0;
    endtask

    task automatic wait_model(input int code, input int budget, input string name);
        int n;
        n = 0;
        while (m_st != code && n < budget) begin
            tick(1);
            n++;
        end
        if (m_st != code) chk(name, m_st, code);
    endtask

    int lat;
    int e0;

    initial begin
        tick(2);
        chk("rst_state", int'(db_estado), 0);
        chk("rst_ctrl", int'(ctrl_vec), 0);
        chk("rst_pergunta", int'(pergunta), 0);
        chk("rst_erros", int'(erros), 0);
        reset = 1'b0;
        tick(1);

        // Full winning game: band question then play question.
        opcode = 2'b11;
        pulse_jogar();
        chk("ignored_confirma_pre", int'(db_estado), 1);
        wait_model(2, 5, "wait_escolhe");
        pulse_confirma();
        wait_model(5, 5, "wait_med");
        chk("med_medir", int'(medir), 1);
        acertou_faixa = 1'b1; tick(1); acertou_faixa = 1'b0;
        chk("fb_state", int'(db_estado), 8);
        opcode = 2'b00;
        pulse_confirma();
        wait_model(6, 5, "wait_resp");
        chk("resp_pergunta", int'(pergunta), 1);
        acertou_play = 1'b1; pronto_play = 1'b1; tick(1);
        acertou_play = 1'b0; pronto_play = 1'b0;
        pulse_confirma();
        chk("win_ganhou", int'(ganhou_o), 1);
        chk("win_pergunta", int'(pergunta), 1);
        chk("win_erros", int'(erros), 0);
        chk("win_state", int'(db_estado), 9);

`ifdef NEUROSYNC_TIMEOUT_EN
        // Timeout on a band question, then on a play question -> lose.
        pulse_jogar();
        chk("new_game_pergunta", int'(pergunta), 0);
        wait_model(2, 5, "wait_escolhe2");
        opcode = 2'b11;
        pulse_confirma();
        wait_model(5, 5, "wait_med2");
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick(1);
            if (estourou) begin lat = n; break; end
        end
        chk("tmo_latency", lat, 10);
        tick(1);
        chk("tmo_erros", int'(erros), 1);
        chk("tmo_state", int'(db_estado), 8);
        opcode = 2'b00;
        pulse_confirma();
        wait_model(6, 5, "wait_resp2");
        acertou_play = 1'b1; pronto_play = 1'b0;
        tick(9);
        chk("hold_no_pronto", int'(db_estado), 6);
        tick(1);
        chk("tmo2_estourou", int'(estourou), 1);
        tick(1);
        acertou_play = 1'b0;
        chk("lose_perdeu", int'(perdeu_o), 1);
        chk("lose_erros", int'(erros), 2);
        chk("lose_state", int'(db_estado), 11);
        pulse_jogar();
        chk("restart_state", int'(db_estado), 1);
        chk("restart_erros", int'(erros), 0);
        chk("restart_pergunta", int'(pergunta), 0);

        // Success on the expiry cycle wins over the timeout.
        wait_model(2, 5, "wait_escolhe3");
        opcode = 2'b11;
        pulse_confirma();
        wait_model(5, 5, "wait_med3");
        e0 = est_count;
        tick(9);
        acertou_faixa = 1'b1; tick(1); acertou_faixa = 1'b0;
        chk("race_state", int'(db_estado), 8);
        chk("race_erros", int'(erros), 0);
        tick(3);
        chk("race_no_estourou", est_count - e0, 0);
`else
        // Without the timeout the wait states hold indefinitely.
        pulse_jogar();
        wait_model(2, 5, "wait_escolhe2");
        opcode = 2'b11;
        pulse_confirma();
        wait_model(5, 5, "wait_med2");
        tick(1000);
        chk("notmo_med_state", int'(db_estado), 5);
        chk("notmo_erros", int'(erros), 0);
        chk("notmo_no_estourou", est_count, 0);
        acertou_faixa = 1'b1; tick(1); acertou_faixa = 1'b0;
        chk("notmo_fb_state", int'(db_estado), 8);
`endif

        // Reset in the middle of the second question.
        opcode = 2'b00;
        pulse_confirma();
        wait_model(6, 5, "wait_resp3");
        acertou_play = 1'b1; pronto_play = 1'b0;
`ifndef NEUROSYNC_TIMEOUT_EN
        tick(1000);
`endif
        chk("pre_reset_state", int'(db_estado), 6);
        chk("pre_reset_pergunta", int'(pergunta), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_state", int'(db_estado), 0);
        chk("midrst_ctrl", int'(ctrl_vec), 0);
        chk("midrst_pergunta", int'(pergunta), 0);
        chk("midrst_erros", int'(erros), 0);
        acertou_play = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(2);
        chk("post_reset_state", int'(db_estado), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
